// File: rtl/fetch_unit_pkg.sv
// Shared MIPS definitions for the fetch stage: FSM states, instruction field
// geometry and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNC_W     = 6;
  localparam int unsigned FUNC_LSB   = 0;
  localparam int unsigned JIDX_W     = 26;
  localparam int unsigned IMM_W      = 16;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack, decode handshake, control-unit
// steering inputs and PC observability.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import mips_pkg::*;

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [DATA_W-1:0]   imem_rdata;
  logic                instr_valid;
  logic                instr_ready;
  logic [DATA_W-1:0]   instr;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  logic                jump;
  logic                pcsrc;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_plus4;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, func, pc, pc_plus4,
    input  imem_ack, imem_rdata, instr_ready, jump, pcsrc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, func, pc, pc_plus4,
    output imem_ack, imem_rdata, instr_ready, jump, pcsrc
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: jump target over branch target over PC+4,
// all arithmetic modulo 2^ADDR_W.
module pc_next
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] instr,
  input  logic              jump,
  input  logic              pcsrc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] w_jump_tgt;
  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_branch_tgt;
  logic              w_unused;

  assign w_unused     = ^instr[DATA_W-1:JIDX_W];
  assign w_jump_tgt   = {pc_plus4[ADDR_W-1:JIDX_W+2], instr[JIDX_W-1:0], 2'b00};
  // Sign-extended word offset; the add wraps naturally in either direction.
  assign w_br_off     = {{(ADDR_W-IMM_W-2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  assign w_branch_tgt = pc_plus4 + w_br_off;

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = w_jump_tgt;
    end else if (pcsrc) begin
      next_pc = w_branch_tgt;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM and held instruction.
// Define FETCH_RETIRE_CNT_EN to add the retire_cnt accepted-instruction counter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_next_pc;
  logic [DATA_W-1:0] r_instr;
  logic              w_load_instr;
  logic              w_advance;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  pc_next #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pc_next (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .jump     (bus.jump),
    .pcsrc    (bus.pcsrc),
    .next_pc  (w_next_pc)
  );

  always_comb begin
    w_state_next = r_state;
    w_load_instr = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack) begin
          w_load_instr = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          w_advance    = 1'b1;
          w_state_next = ST_FETCH;
        end
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_instr) r_instr <= bus.imem_rdata;
      if (w_advance)    r_pc    <= w_next_pc;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign bus.imem_req    = (r_state == ST_FETCH);
  assign bus.instr_valid = (r_state == ST_HOLD);
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[OPCODE_LSB+OPCODE_W-1:OPCODE_LSB];
  assign bus.func        = r_instr[FUNC_LSB+FUNC_W-1:FUNC_LSB];

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_advance) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: randomized memory latency, decode stalls and
// jump/branch steering checked against an arithmetic next-PC reference model.
module tb_fetch_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] RPC_J = 32'h4000_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_j = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_j ();

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] retire_cnt_j;
`endif

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(RPC_J)) u_dut_j (
    .clk (clk),
    .rst (rst_j),
    .bus (bus_j)
`ifdef FETCH_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt_j)
`endif
  );

  typedef struct { logic [31:0] val; int due; } exp_addr_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; int due; } exp_instr_t;
  typedef struct { int lat; logic [31:0] rdata; int stall; logic j; logic b; } txn_t;

  exp_addr_t  addr_q[$];
  exp_instr_t instr_q[$];
  txn_t       dir_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference next PC from the architectural rules, using plain 64-bit arithmetic.
  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic j, input logic b);
    logic [63:0] p4, tgt;
    int          imm;
    p4 = ({32'd0, pc} + 64'd4) % 64'h1_0000_0000;
    if (j) begin
      tgt = (p4 / 64'h1000_0000) * 64'h1000_0000 + ({32'd0, ins} % 64'h0400_0000) * 64'd4;
    end else if (b) begin
      imm = int'(ins % 32'h0001_0000);
      if (imm >= 32768) imm = imm - 65536;
      tgt = (p4 + 64'(longint'(imm) * 4)) % 64'h1_0000_0000;
    end else begin
      tgt = p4;
    end
    return tgt[31:0];
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.lat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    t.rdata = $urandom;
    t.stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
    t.j     = ($urandom_range(0, 4) == 0);
    t.b     = ($urandom_range(0, 2) == 0);
    return t;
  endfunction

  function automatic void add_dir(input int lat, input logic [31:0] d, input int stall,
                                  input logic j, input logic b);
    txn_t t;
    t.lat = lat; t.rdata = d; t.stall = stall; t.j = j; t.b = b;
    dir_q.push_back(t);
  endfunction

  // Driver / reference-model state
  txn_t        cur;
  bit          cur_active = 0;
  int          wait_cnt = 0;
  logic [31:0] model_pc = RPC;
  logic [31:0] model_instr = '0;
  bit          hold_off = 0;
  bit          stop_after_accept = 0;
  int          accepts = 0;
  bit          jump_done = 0;

  task automatic drive_cycle();
    @(negedge clk);
    bus.imem_ack    = $urandom_range(0, 1) == 1;
    bus.imem_rdata  = $urandom;
    bus.instr_ready = $urandom_range(0, 1) == 1;
    bus.jump        = $urandom_range(0, 1) == 1;
    bus.pcsrc       = $urandom_range(0, 1) == 1;
    if (hold_off) begin
      bus.imem_ack    = 1'b0;
      bus.instr_ready = 1'b0;
    end else if (bus.imem_req) begin
      bus.instr_ready = 1'b0;
      if (!cur_active) begin
        cur        = (dir_q.size() > 0) ? dir_q.pop_front() : rand_txn();
        cur_active = 1;
        wait_cnt   = 0;
      end
      if (wait_cnt >= cur.lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = cur.rdata;
        model_instr    = cur.rdata;
        instr_q.push_back('{cur.rdata, model_pc, cyc + 1});
        wait_cnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt++;
      end
    end else if (bus.instr_valid) begin
      if (cur_active && wait_cnt >= cur.stall) begin
        bus.instr_ready = 1'b1;
        bus.jump        = cur.j;
        bus.pcsrc       = cur.b;
        model_pc        = ref_next_pc(model_pc, model_instr, cur.j, cur.b);
        addr_q.push_back('{model_pc, cyc + 1});
        accepts++;
        cur_active = 0;
        wait_cnt   = 0;
        if (stop_after_accept) hold_off = 1;
      end else begin
        bus.instr_ready = 1'b0;
        wait_cnt++;
      end
    end
  endtask

  // Monitor: pops expectations when the DUT raises a request or presents an instruction.
  initial begin : monitor
    bit         prev_req = 0;
    bit         prev_valid = 0;
    exp_addr_t  ea;
    exp_instr_t ei;
    ea = '{32'd0, 0};
    ei = '{32'd0, 32'd0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_req   = 0;
        prev_valid = 0;
      end else begin
        if (bus.imem_req) begin
          if (!prev_req) begin
            if (addr_q.size() == 0) begin
              chk("unexpected_req", 32'd1, 32'd0);
            end else begin
              ea = addr_q.pop_front();
              chk("req_cycle", cyc, ea.due);
              chk("imem_addr", bus.imem_addr, ea.val);
              chk("pc_at_req", bus.pc, ea.val);
            end
          end else begin
            chk("imem_addr_stable", bus.imem_addr, ea.val);
          end
        end
        if (bus.instr_valid) begin
          if (!prev_valid) begin
            if (instr_q.size() == 0) begin
              chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
              ei = instr_q.pop_front();
              chk("valid_cycle", cyc, ei.due);
              chk("instr", bus.instr, ei.instr);
              chk("opcode", 32'(bus.opcode), ei.instr >> 26);
              chk("func", 32'(bus.func), ei.instr % 32'd64);
              chk("pc_at_valid", bus.pc, ei.pc);
              chk("pc_plus4", bus.pc_plus4, ei.pc + 32'd4);
            end
          end else begin
            chk("instr_held", bus.instr, ei.instr);
            chk("pc_held", bus.pc, ei.pc);
          end
        end
        if (addr_q.size() > 0 && addr_q[0].due < cyc) begin
          chk("req_late", 32'd0, 32'd1);
          void'(addr_q.pop_front());
        end
        if (instr_q.size() > 0 && instr_q[0].due < cyc) begin
          chk("valid_late", 32'd0, 32'd1);
          void'(instr_q.pop_front());
        end
        prev_req   = bus.imem_req;
        prev_valid = bus.instr_valid;
      end
    end
  end

  // Jump-over-branch case needs a PC in the 0x4xxx_xxxx region, hence a second instance.
  initial begin : jump_test
    bit ok;
    bus_j.imem_ack = 1'b0; bus_j.imem_rdata = '0; bus_j.instr_ready = 1'b0;
    bus_j.jump = 1'b0; bus_j.pcsrc = 1'b0;
    repeat (3) @(negedge clk);
    rst_j = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      ok = bus_j.imem_req;
    end
    chk("j_req", 32'(ok), 32'd1);
    chk("j_addr", bus_j.imem_addr, RPC_J);
    @(negedge clk);
    bus_j.imem_ack = 1'b1; bus_j.imem_rdata = 32'h0800_0100;
    @(posedge clk); #1;
    chk("j_valid", 32'(bus_j.instr_valid), 32'd1);
    chk("j_opcode", 32'(bus_j.opcode), 32'd2);
    chk("j_pc", bus_j.pc, RPC_J);
    @(negedge clk);
    bus_j.imem_ack = 1'b0; bus_j.instr_ready = 1'b1; bus_j.jump = 1'b1; bus_j.pcsrc = 1'b1;
    @(posedge clk); #1;
    chk("j_next_req", 32'(bus_j.imem_req), 32'd1);
    chk("j_next_addr", bus_j.imem_addr, 32'h4000_0400);
`ifdef FETCH_RETIRE_CNT_EN
    chk("j_retire_cnt", retire_cnt_j, 32'd1);
`endif
    @(negedge clk);
    bus_j.instr_ready = 1'b0; bus_j.jump = 1'b0; bus_j.pcsrc = 1'b0;
    jump_done = 1;
  end

  initial begin : main
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.jump = 1'b0; bus.pcsrc = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", bus.pc, RPC);
    chk("rst_instr", bus.instr, 32'd0);
`ifdef FETCH_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif

    add_dir(0, 32'h2008_0005, 0, 1'b0, 1'b0); // 0x0  -> 0x4
    add_dir(0, 32'h0109_5020, 0, 1'b0, 1'b0); // 0x4  -> 0x8
    add_dir(3, 32'h0000_0000, 4, 1'b0, 1'b0); // 0x8  -> 0xC, memory wait + decode stall
    add_dir(1, 32'h0000_0000, 0, 1'b0, 1'b0); // 0xC  -> 0x10
    add_dir(0, 32'h1000_FFFE, 0, 1'b0, 1'b1); // 0x10 -> 0xC
    add_dir(0, 32'h1000_FFFD, 2, 1'b0, 1'b1); // 0xC  -> 0x4
    add_dir(0, 32'h1000_FFFD, 0, 1'b0, 1'b1); // 0x4  -> 0xFFFF_FFFC
    add_dir(2, 32'h0000_0000, 0, 1'b0, 1'b0); // 0xFFFF_FFFC -> 0x0
    add_dir(0, 32'h0800_0040, 0, 1'b1, 1'b1); // 0x0  -> 0x100

    @(negedge clk);
    rst = 1'b0;
    model_pc = RPC;
    addr_q.push_back('{RPC, cyc + 1});
    chk("req_low_at_release", 32'(bus.imem_req), 32'd0);
    @(posedge clk); #1;
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, RPC);

    repeat (600) drive_cycle();
    stop_after_accept = 1;
    for (int i = 0; i < 60 && !hold_off; i++) drive_cycle();
    chk("stop_reached", 32'(hold_off), 32'd1);
    repeat (2) drive_cycle();
`ifdef FETCH_RETIRE_CNT_EN
    chk("retire_cnt_run", retire_cnt, 32'(accepts));
`endif

    // Reset while a fetch is outstanding, then a late ack while IDLE.
    chk("req_before_reset", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    addr_q.delete();
    instr_q.delete();
    cur_active = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = $urandom;
    model_pc = RPC;
    accepts = 0;
    addr_q.push_back('{RPC, cyc + 1});
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_pc", bus.pc, RPC);
`ifdef FETCH_RETIRE_CNT_EN
    chk("midrst_retire_cnt", retire_cnt, 32'd0);
`endif
    repeat (3) begin
      drive_cycle();
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("post_rst_pc", bus.pc, RPC);
    end

    hold_off = 0;
    stop_after_accept = 0;
    add_dir(0, 32'h0000_0020, 0, 1'b0, 1'b0);
    add_dir(2, 32'h0000_0022, 1, 1'b0, 1'b0);
    add_dir(0, 32'h0000_0024, 0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && accepts < 3; i++) drive_cycle();
    chk("three_accepts", 32'(accepts), 32'd3);
    @(posedge clk); #1;
`ifdef FETCH_RETIRE_CNT_EN
    chk("retire_cnt_three", retire_cnt, 32'd3);
`endif
    hold_off = 1;
    repeat (3) drive_cycle();

    for (int i = 0; i < 100 && !jump_done; i++) @(posedge clk);
    chk("jump_test_done", 32'(jump_done), 32'd1);
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("instr_q_drained", 32'(instr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
